muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit that owns the HI/LO register pair of the MIPS core. It accepts MULT/MULTU/DIV/DIVU requests from the EX stage and raises a stall while it computes. It takes MTHI/MTLO writes (`we_hi`/`we_lo`) from the ALU and presents the current HI/LO back to the ALU as its `hi_in`/`lo_in` operands.

## Interface
- `DATA_W`, 32, operand and HI/LO width; equals `RegDataWidth`.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `start_i`  in  1  request; sampled only in IDLE.
- `op_i`  in  2  `Mult`=00, `Multu`=01, `Div`=10, `Divu`=11.
- `srcA`, `srcB`  in  DATA_W  multiplicand/dividend, multiplier/divisor.
- `flush_i`  in  1  pipeline flush; aborts any in-flight operation.
- `we_hi`, `we_lo`  in  1 each  MTHI/MTLO write enables from ALU.
- `hi_wdata`, `lo_wdata`  in  DATA_W  MTHI/MTLO data (ALU `hi_out`/`lo_out`).
- `busy_o`  out  1  stall request to pipeline control.
- `done_o`  out  1  one-cycle pulse; HI/LO already hold the new result.
- `hi_out`, `lo_out`  out  DATA_W  current HI/LO register contents (to ALU `hi_in`/`lo_in`).

## Operation
- States: IDLE, MUL, DIV, DONE.
- Reset (`rst`=0): state IDLE, HI=LO=0, iteration counter 0, `busy_o`=0, `done_o`=0.
- IDLE:
  - `start_i`=1 and `flush_i`=0: latch `srcA`, `srcB` and `op_i`.
  - Go to MUL for Mult/Multu.
  - Go to DIV for Div/Divu with nonzero divisor.
  - Go straight to DONE for a zero divisor.
- Signed ops: iterate on operand magnitudes.
  - Product sign = sign(A) XOR sign(B).
  - Quotient sign = sign(A) XOR sign(B).
  - Remainder sign = sign(A).
  - Negate results on the edge entering DONE.
- MUL: shift-add, one multiplier bit per cycle, 32 cycles, 64-bit accumulator. Result: HI = bits [63:32], LO = bits [31:0].
- DIV: restoring division, one quotient bit per cycle, 32 cycles. Result: LO = quotient, HI = remainder.
- Divide by zero: LO=0xFFFFFFFF, HI=srcA, for both signed and unsigned.
- HI/LO are written with the result on the edge entering DONE. DONE asserts `done_o`, then returns to IDLE unconditionally.
- MTHI/MTLO: `we_hi`/`we_lo` write HI/LO on any cycle. On the edge entering DONE, the computed result takes priority over both.
- `start_i` outside IDLE: ignored; the pipeline is already stalled.
- `flush_i` in MUL/DIV: return to IDLE next edge; HI/LO untouched; no `done_o`.
- `flush_i` in DONE: no effect; the result is already committed.
- `flush_i` together with `start_i` in IDLE: flush wins; nothing latched.
- Reset mid-operation: immediate return to reset values; the partial result is discarded.

## Timing
- Cycle N = cycle in which `start_i` is sampled high in IDLE.
- `busy_o` = (IDLE & `start_i` & ~`flush_i`) | MUL | DIV. It is combinational, so EX stalls in cycle N itself.
- Iterative MUL/DIV: states occupy cycles N+1..N+32. `done_o` is high in N+33. New HI/LO are visible on `hi_out`/`lo_out` from N+33.
- Divide by zero: `done_o` in N+1.
- Next `start_i` is accepted from N+34 (or N+2 for divide by zero).
- `hi_out`/`lo_out` are pure register outputs; MTHI/MTLO data written at edge E is visible after E.

## Configuration
- `MDU_FAST_MUL_EN` defined: MUL lasts one cycle, using a single combinational 32x32→64 multiply of the latched operands. `done_o` is in N+2.
- `MDU_FAST_MUL_EN` undefined: 32-cycle shift-add as above.
- Division is iterative in both builds. Results are bit-identical in both builds.

## Structure
- Shared package `mdu_pkg`: op encodings (`Mult`, `Multu`, `Div`, `Divu`), state enum, `DATA_W`, iteration count constant (32), divide-by-zero quotient constant.
- One sub-module: `mdu_divider`, the restoring divider core. It takes magnitudes and a step enable, and outputs quotient/remainder.
- Sign handling, multiplier, FSM and HI/LO registers stay in `muldiv_unit`.

## Test plan
- Multu 0xFFFFFFFF × 0xFFFFFFFF → `done_o` at N+33 (N+2 with fast mul); HI=0xFFFFFFFE, LO=0x00000001.
- Mult 0xFFFFFFFD (−3) × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- Div 0xFFFFFFF9 (−7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Divu 100 / 7 → LO=0x0000000E, HI=0x00000002.
- Div 0x12345678 / 0 → `done_o` at N+1; LO=0xFFFFFFFF, HI=0x12345678.
- HI=LO=0x11111111 set via MTHI/MTLO, Divu started, `flush_i` at N+10 → IDLE at N+11; HI/LO stay 0x11111111; no `done_o`.
- `we_hi`=1 with 0xAAAAAAAA on the edge entering DONE of Multu 2×3 → HI=0, LO=6 (result wins). The same write one cycle later → HI=0xAAAAAAAA.

Source files
------------

// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the multiply/divide unit: operand width, operation
// encodings, FSM state type, iteration constants and a magnitude helper.
// -----------------------------------------------------------------------------
package mdu_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ITER_CNT = 32;
    localparam int unsigned CNT_W    = 5;

    localparam logic [CNT_W-1:0]  LAST_ITER = 5'd31;
    localparam logic [DATA_W-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        Mult  = 2'b00,
        Multu = 2'b01,
        Div   = 2'b10,
        Divu  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } mdu_state_e;

    // Absolute value of a two's-complement operand when the op is signed;
    // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v,
                                              input logic sgn);
        logic [DATA_W-1:0] r;
        if (sgn && v[DATA_W-1]) begin
            r = ~v + 32'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// -----------------------------------------------------------------------------
// mdu_divider
// Restoring divider core working on unsigned magnitudes, one quotient bit per
// enabled step.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   load_i          capture dividend/divisor and clear the partial remainder
//   step_i          perform one restoring step
//   dividend_i      dividend magnitude
//   divisor_i       divisor magnitude (nonzero when stepping)
//   quo_o, rem_o    quotient/remainder as they stand AFTER the current step,
//                   so the caller can commit the final value on the same edge
//                   that performs the last step
// -----------------------------------------------------------------------------
module mdu_divider
    import mdu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] quo_o,
    output logic [DATA_W-1:0] rem_o
);

    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic [DATA_W:0]   trial_s;
    logic [DATA_W-1:0] quo_step_s;
    logic [DATA_W-1:0] rem_step_s;

    // One restoring step: the quotient register doubles as the dividend
    // shift source; trial_s[DATA_W] set means the subtraction borrowed.
    always_comb begin
        trial_s    = {rem_q, quo_q[DATA_W-1]} - {1'b0, dvs_q};
        quo_step_s = {quo_q[DATA_W-2:0], ~trial_s[DATA_W]};
        if (trial_s[DATA_W]) begin
            rem_step_s = {rem_q[DATA_W-2:0], quo_q[DATA_W-1]};
        end else begin
            rem_step_s = trial_s[DATA_W-1:0];
        end
        quo_o = quo_step_s;
        rem_o = rem_step_s;
    end

    // Next-state selection for the divider datapath registers.
    always_comb begin
        quo_d = quo_q;
        rem_d = rem_q;
        dvs_d = dvs_q;
        if (load_i) begin
            quo_d = dividend_i;
            rem_d = 32'd0;
            dvs_d = divisor_i;
        end else if (step_i) begin
            quo_d = quo_step_s;
            rem_d = rem_step_s;
        end else begin
            quo_d = quo_q;
            rem_d = rem_q;
        end
    end

    // Divider datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quo_q <= 32'd0;
            rem_q <= 32'd0;
            dvs_q <= 32'd0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative multiply/divide unit owning the HI/LO register pair.
// Build option: define MDU_FAST_MUL_EN for a single-cycle combinational
// multiply; otherwise multiplication is a 32-cycle shift-add.
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   start_i, op_i          request and operation (sampled in IDLE only)
//   srcA, srcB             multiplicand/dividend, multiplier/divisor
//   flush_i                abort in-flight operation (not in DONE)
//   we_hi/we_lo, *_wdata   MTHI/MTLO writes
//   busy_o                 combinational stall request
//   done_o                 one-cycle pulse, HI/LO already updated
//   hi_out, lo_out         HI/LO register contents
// -----------------------------------------------------------------------------
module muldiv_unit
    import mdu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] srcA,
    input  logic [DATA_W-1:0] srcB,
    input  logic              flush_i,
    input  logic              we_hi,
    input  logic              we_lo,
    input  logic [DATA_W-1:0] hi_wdata,
    input  logic [DATA_W-1:0] lo_wdata,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    mdu_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic [1:0]          op_q, op_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic                accept_s;
    logic                sgn_s;
    logic [DATA_W-1:0]   mag_a_s, mag_b_s;
    logic [2*DATA_W-1:0] prod_next_s, prod_res_s;
    logic                mul_last_s;
    logic [DATA_W-1:0]   quo_s, rem_s, quo_res_s, rem_res_s;
    logic [DATA_W-1:0]   res_hi_s, res_lo_s;
    logic                commit_s;

    assign accept_s = (state_q == ST_IDLE) && start_i && !flush_i;
    assign sgn_s    = ~op_q[0];
    assign mag_a_s  = mag(a_q, sgn_s);
    assign mag_b_s  = mag(b_q, sgn_s);

`ifdef MDU_FAST_MUL_EN
    assign prod_next_s = {32'd0, mag_a_s} * {32'd0, mag_b_s};
    assign mul_last_s  = 1'b1;
`else
    logic [2*DATA_W-1:0] prod_q;
    logic [DATA_W:0]     psum_s;

    // Shift-add step: multiplier bit cnt_q selects whether the multiplicand
    // is added to the upper half before the accumulator shifts right.
    always_comb begin
        if (mag_b_s[cnt_q]) begin
            psum_s = {1'b0, prod_q[2*DATA_W-1:DATA_W]} + {1'b0, mag_a_s};
        end else begin
            psum_s = {1'b0, prod_q[2*DATA_W-1:DATA_W]};
        end
        prod_next_s = {psum_s, prod_q[DATA_W-1:1]};
    end
    assign mul_last_s = (cnt_q == LAST_ITER);

    // Product accumulator: cleared on accept, advanced each MUL cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_q <= 64'd0;
        end else if (accept_s) begin
            prod_q <= 64'd0;
        end else if (state_q == ST_MUL) begin
            prod_q <= prod_next_s;
        end else begin
            prod_q <= prod_q;
        end
    end
`endif

    mdu_divider u_div (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept_s && op_i[1]),
        .step_i     (state_q == ST_DIV),
        .dividend_i (mag(srcA, ~op_i[0])),
        .divisor_i  (mag(srcB, ~op_i[0])),
        .quo_o      (quo_s),
        .rem_o      (rem_s)
    );

    // Sign fix-up applied to the value committed on the edge entering DONE.
    always_comb begin
        if (sgn_s && (a_q[DATA_W-1] ^ b_q[DATA_W-1])) begin
            prod_res_s = ~prod_next_s + 64'd1;
            quo_res_s  = ~quo_s + 32'd1;
        end else begin
            prod_res_s = prod_next_s;
            quo_res_s  = quo_s;
        end
        if (sgn_s && a_q[DATA_W-1]) begin
            rem_res_s = ~rem_s + 32'd1;
        end else begin
            rem_res_s = rem_s;
        end
    end

    // FSM next state, iteration counter, operand latch and result selection.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        commit_s = 1'b0;
        if (op_q[1]) begin
            res_hi_s = rem_res_s;
            res_lo_s = quo_res_s;
        end else begin
            res_hi_s = prod_res_s[2*DATA_W-1:DATA_W];
            res_lo_s = prod_res_s[DATA_W-1:0];
        end
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    a_d   = srcA;
                    b_d   = srcB;
                    op_d  = op_i;
                    cnt_d = 5'd0;
                    if (!op_i[1]) begin
                        state_d = ST_MUL;
                    end else if (srcB == 32'd0) begin
                        // Divide by zero commits immediately from the inputs.
                        state_d  = ST_DONE;
                        commit_s = 1'b1;
                        res_hi_s = srcA;
                        res_lo_s = DIV0_QUOT;
                    end else begin
                        state_d = ST_DIV;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (mul_last_s) begin
                    state_d  = ST_DONE;
                    commit_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ST_DIV: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == LAST_ITER) begin
                    state_d  = ST_DONE;
                    commit_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // HI/LO next value: a committing result overrides MTHI/MTLO.
    always_comb begin
        if (commit_s) begin
            hi_d = res_hi_s;
            lo_d = res_lo_s;
        end else begin
            hi_d = we_hi ? hi_wdata : hi_q;
            lo_d = we_lo ? lo_wdata : lo_q;
        end
    end

    // Control and architectural state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 2'b00;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy_o = accept_s || (state_q == ST_MUL) || (state_q == ST_DIV);
    assign done_o = (state_q == ST_DONE);
    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] srcA = 32'd0;
    logic [31:0] srcB = 32'd0;
    logic        flush_i = 1'b0;
    logic        we_hi = 1'b0;
    logic        we_lo = 1'b0;
    logic [31:0] hi_wdata = 32'd0;
    logic [31:0] lo_wdata = 32'd0;
    logic        busy_o, done_o;
    logic [31:0] hi_out, lo_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .srcA(srcA), .srcB(srcB), .flush_i(flush_i),
        .we_hi(we_hi), .we_lo(we_lo), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
        .busy_o(busy_o), .done_o(done_o), .hi_out(hi_out), .lo_out(lo_out)
    );

    // Issue a request in cycle N and wait for done_o; lat = cycle offset of
    // done_o relative to N (-1 on timeout). Leaves time at the done negedge.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int lat, output logic busy_n);
        @(negedge clk);
        start_i = 1'b1; op_i = op; srcA = a; srcB = b;
        #1 busy_n = busy_o;
        @(negedge clk);
        start_i = 1'b0;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            if (done_o) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        #1;
        n_tests++; if (hi_out !== 32'd0) begin n_fail++; $display("FAIL reset_hi got %h want %h", hi_out, 32'd0); end
        n_tests++; if (lo_out !== 32'd0) begin n_fail++; $display("FAIL reset_lo got %h want %h", lo_out, 32'd0); end
        n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_o); end
        n_tests++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done_o); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_multu_max;
        int lat; logic b;
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, b);
        n_tests++; if (b !== 1'b1) begin n_fail++; $display("FAIL multu_busy_N got %b want 1", b); end
        n_tests++; if (lat != MUL_LAT) begin n_fail++; $display("FAIL multu_latency got %0d want %0d", lat, MUL_LAT); end
        n_tests++; if (hi_out !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi got %h want fffffffe", hi_out); end
        n_tests++; if (lo_out !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo got %h want 00000001", lo_out); end
        @(negedge clk);
        n_tests++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL done_pulse got %b want 0", done_o); end
    endtask

    task automatic test_mult_signed;
        int lat; logic b;
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, lat, b);
        n_tests++; if (lat != MUL_LAT) begin n_fail++; $display("FAIL mult_latency got %0d want %0d", lat, MUL_LAT); end
        n_tests++; if (hi_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi got %h want ffffffff", hi_out); end
        n_tests++; if (lo_out !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mult_lo got %h want fffffff1", lo_out); end
    endtask

    task automatic test_divide;
        int lat; logic b;
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, b);
        n_tests++; if (lat != DIV_LAT) begin n_fail++; $display("FAIL div_latency got %0d want %0d", lat, DIV_LAT); end
        n_tests++; if (lo_out !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo got %h want fffffffd", lo_out); end
        n_tests++; if (hi_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi got %h want ffffffff", hi_out); end
        run_op(OP_DIVU, 32'd100, 32'd7, lat, b);
        n_tests++; if (lo_out !== 32'h0000_000E) begin n_fail++; $display("FAIL divu_lo got %h want 0000000e", lo_out); end
        n_tests++; if (hi_out !== 32'h0000_0002) begin n_fail++; $display("FAIL divu_hi got %h want 00000002", hi_out); end
    endtask

    // Divide by zero, then the next request issued at N+2 must be accepted.
    task automatic test_div_zero_back_to_back;
        int lat; logic b;
        run_op(OP_DIV, 32'h1234_5678, 32'd0, lat, b);
        n_tests++; if (lat != 1) begin n_fail++; $display("FAIL div0_latency got %0d want 1", lat); end
        n_tests++; if (lo_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div0_lo got %h want ffffffff", lo_out); end
        n_tests++; if (hi_out !== 32'h1234_5678) begin n_fail++; $display("FAIL div0_hi got %h want 12345678", hi_out); end
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'h0001_0000, lat, b);
        n_tests++; if (b !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got %b want 1", b); end
        n_tests++; if (lat != DIV_LAT) begin n_fail++; $display("FAIL b2b_latency got %0d want %0d", lat, DIV_LAT); end
        n_tests++; if (lo_out !== 32'h0000_FFFF) begin n_fail++; $display("FAIL b2b_lo got %h want 0000ffff", lo_out); end
        n_tests++; if (hi_out !== 32'h0000_FFFF) begin n_fail++; $display("FAIL b2b_hi got %h want 0000ffff", hi_out); end
    endtask

    task automatic test_flush;
        int seen;
        @(negedge clk);
        we_hi = 1'b1; we_lo = 1'b1; hi_wdata = 32'h1111_1111; lo_wdata = 32'h1111_1111;
        @(negedge clk);
        we_hi = 1'b0; we_lo = 1'b0;
        n_tests++; if (hi_out !== 32'h1111_1111) begin n_fail++; $display("FAIL mthi got %h want 11111111", hi_out); end
        n_tests++; if (lo_out !== 32'h1111_1111) begin n_fail++; $display("FAIL mtlo got %h want 11111111", lo_out); end
        start_i = 1'b1; op_i = OP_DIVU; srcA = 32'd100; srcB = 32'd7;
        @(negedge clk);
        start_i = 1'b0;
        for (int k = 1; k < 10; k++) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_idle busy got %b want 0", busy_o); end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (done_o) seen++;
            @(negedge clk);
        end
        n_tests++; if (seen != 0) begin n_fail++; $display("FAIL flush_no_done got %0d pulses want 0", seen); end
        n_tests++; if (hi_out !== 32'h1111_1111) begin n_fail++; $display("FAIL flush_hi got %h want 11111111", hi_out); end
        n_tests++; if (lo_out !== 32'h1111_1111) begin n_fail++; $display("FAIL flush_lo got %h want 11111111", lo_out); end
        // start together with flush in IDLE: nothing is accepted
        start_i = 1'b1; flush_i = 1'b1; op_i = OP_MULTU; srcA = 32'd2; srcB = 32'd3;
        #1;
        n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_start busy got %b want 0", busy_o); end
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (done_o || busy_o) seen++;
            @(negedge clk);
        end
        n_tests++; if (seen != 0) begin n_fail++; $display("FAIL flush_start_idle got %0d active cycles want 0", seen); end
    endtask

    // MTHI on the edge entering DONE loses; one cycle later it lands.
    task automatic test_result_priority;
        int lat;
        @(negedge clk);
        start_i = 1'b1; op_i = OP_MULTU; srcA = 32'd2; srcB = 32'd3;
        @(negedge clk);
        start_i = 1'b0;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            if (k == MUL_LAT - 1) begin we_hi = 1'b1; hi_wdata = 32'hAAAA_AAAA; end
            else we_hi = 1'b0;
            if (done_o) begin lat = k; break; end
            @(negedge clk);
        end
        n_tests++; if (lat != MUL_LAT) begin n_fail++; $display("FAIL prio_latency got %0d want %0d", lat, MUL_LAT); end
        n_tests++; if (hi_out !== 32'd0) begin n_fail++; $display("FAIL prio_hi got %h want 00000000", hi_out); end
        n_tests++; if (lo_out !== 32'd6) begin n_fail++; $display("FAIL prio_lo got %h want 00000006", lo_out); end
        we_hi = 1'b1; hi_wdata = 32'hAAAA_AAAA;
        @(negedge clk);
        we_hi = 1'b0;
        n_tests++; if (hi_out !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL late_mthi got %h want aaaaaaaa", hi_out); end
        n_tests++; if (lo_out !== 32'd6) begin n_fail++; $display("FAIL late_mthi_lo got %h want 00000006", lo_out); end
    endtask

    task automatic test_reset_mid_op;
        int seen;
        @(negedge clk);
        start_i = 1'b1; op_i = OP_MULTU; srcA = 32'hFFFF_FFFF; srcB = 32'hFFFF_FFFF;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", busy_o); end
        n_tests++; if (hi_out !== 32'd0) begin n_fail++; $display("FAIL rst_mid_hi got %h want 00000000", hi_out); end
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (done_o) seen++;
            @(negedge clk);
        end
        n_tests++; if (seen != 0) begin n_fail++; $display("FAIL rst_mid_no_done got %0d want 0", seen); end
        n_tests++; if (lo_out !== 32'd0) begin n_fail++; $display("FAIL rst_mid_lo got %h want 00000000", lo_out); end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_mult_signed();
        test_divide();
        test_div_zero_back_to_back();
        test_flush();
        test_result_priority();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
